// File: rtl/timer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : timer_sequencer
// Brief    : Button debounce, 100 Hz tick and run/stop control FSM for the
//            stopwatch/countdown timer datapath.
// Revision : 1.0 - initial release
// ============================================================================
module timer_sequencer #(
    parameter int S100_PERIOD = 1_000_000,
    parameter int DB_TICKS    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btnu,
    input  logic btnd,
    input  logic btnc,
    input  logic btnl,
    input  logic btnr,
    input  logic zero,
    output logic clks100,
    output logic mode,
    output logic timer_clr,
    output logic clr,
    output logic ld,
    output logic dir,
    output logic state
);

    localparam int c_CNT_W = $clog2(S100_PERIOD);
    localparam int c_DB_W  = $clog2(DB_TICKS + 1);
    localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(S100_PERIOD - 1);
    localparam logic [c_DB_W-1:0]  c_DB_LAST   = c_DB_W'(DB_TICKS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Button vector order is also the priority order: bit 4 wins.
    localparam int c_B_D = 0;
    localparam int c_B_L = 1;
    localparam int c_B_C = 2;
    localparam int c_B_U = 3;
    localparam int c_B_R = 4;

    logic [c_CNT_W-1:0] r_tick_cnt;
    logic               w_tick;
    logic [4:0]         w_btn_raw;
    logic [4:0]         w_press;
    logic [4:0]         w_evt;

    logic [1:0] r_fsm;
    logic [1:0] w_fsm_nxt;
    logic       r_mode, r_dir, r_clr, r_timer_clr, r_ld, r_state;
    logic       w_mode_nxt, w_dir_nxt, w_clr_nxt, w_timer_clr_nxt, w_ld_nxt, w_state_nxt;
    logic       w_clr_req;

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_btn_raw = {btnr, btnu, btnc, btnl, btnd};

    generate
        for (genvar g = 0; g < 5; g++) begin : g_btn
            logic [1:0]        r_sync;
            logic              r_level;
            logic [c_DB_W-1:0] r_db_cnt;
            logic              w_differs;
            logic              w_accept;

            assign w_differs  = (r_sync[1] != r_level);
            assign w_accept   = w_tick && w_differs && (r_db_cnt == c_DB_LAST);
            assign w_press[g] = w_accept && r_sync[1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sync   <= 2'b00;
                    r_level  <= 1'b0;
                    r_db_cnt <= '0;
                end else begin
                    r_sync <= {r_sync[0], w_btn_raw[g]};
                    if (w_tick) begin
                        // A matching sample breaks the run of differing samples.
                        if (!w_differs || w_accept) begin
                            r_db_cnt <= '0;
                        end else begin
                            r_db_cnt <= r_db_cnt + 1'b1;
                        end
                        if (w_accept) begin
                            r_level <= r_sync[1];
                        end
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_evt = 5'b00000;
        if (w_press[c_B_R])      w_evt[c_B_R] = 1'b1;
        else if (w_press[c_B_U]) w_evt[c_B_U] = 1'b1;
        else if (w_press[c_B_C]) w_evt[c_B_C] = 1'b1;
        else if (w_press[c_B_L]) w_evt[c_B_L] = 1'b1;
        else if (w_press[c_B_D]) w_evt[c_B_D] = 1'b1;
    end

    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_mode_nxt = r_mode;
        w_dir_nxt  = r_dir;
        w_clr_req  = 1'b0;
        w_ld_nxt   = 1'b0;
        case (r_fsm)
            c_ST_IDLE: begin
                if (w_evt[c_B_R])      w_clr_req  = 1'b1;
                else if (w_evt[c_B_U]) w_ld_nxt   = 1'b1;
                else if (w_evt[c_B_C]) w_fsm_nxt  = c_ST_RUN;
                else if (w_evt[c_B_L]) w_mode_nxt = ~r_mode;
                else if (w_evt[c_B_D]) w_dir_nxt  = ~r_dir;
            end
            c_ST_RUN: begin
                w_clr_req = w_evt[c_B_R];
                // Auto-stop wins over a stop request; both leave the count held.
                if (r_dir && zero)     w_fsm_nxt = c_ST_DONE;
                else if (w_evt[c_B_C]) w_fsm_nxt = c_ST_IDLE;
            end
            c_ST_DONE: begin
                if (|w_evt) begin
                    w_fsm_nxt = c_ST_IDLE;
                    w_clr_req = w_evt[c_B_R];
                end
            end
            default: w_fsm_nxt = c_ST_IDLE;
        endcase
        w_clr_nxt       = w_clr_req & r_mode;
        w_timer_clr_nxt = w_clr_req & ~r_mode;
        w_state_nxt     = (w_fsm_nxt == c_ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm       <= c_ST_IDLE;
            r_mode      <= 1'b0;
            r_dir       <= 1'b0;
            r_clr       <= 1'b0;
            r_timer_clr <= 1'b0;
            r_ld        <= 1'b0;
            r_state     <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_mode      <= w_mode_nxt;
            r_dir       <= w_dir_nxt;
            r_clr       <= w_clr_nxt;
            r_timer_clr <= w_timer_clr_nxt;
            r_ld        <= w_ld_nxt;
            r_state     <= w_state_nxt;
        end
    end

    assign clks100   = w_tick;
    assign mode      = r_mode;
    assign dir       = r_dir;
    assign clr       = r_clr;
    assign timer_clr = r_timer_clr;
    assign ld        = r_ld;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_timer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_sequencer
// Brief    : Directed self-checking bench for timer_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_sequencer;

    localparam int c_PERIOD = 10;
    localparam logic [4:0] c_D = 5'b00001;
    localparam logic [4:0] c_L = 5'b00010;
    localparam logic [4:0] c_C = 5'b00100;
    localparam logic [4:0] c_U = 5'b01000;
    localparam logic [4:0] c_R = 5'b10000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic zero = 1'b0;
    logic [4:0] r_btn = 5'b00000;
    logic clks100, mode, timer_clr, clr, ld, dir, state;
    int   n_vec = 0;
    int   n_err = 0;

    timer_sequencer #(
        .S100_PERIOD(c_PERIOD),
        .DB_TICKS   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btnu     (r_btn[3]),
        .btnd     (r_btn[0]),
        .btnc     (r_btn[2]),
        .btnl     (r_btn[1]),
        .btnr     (r_btn[4]),
        .zero     (zero),
        .clks100  (clks100),
        .mode     (mode),
        .timer_clr(timer_clr),
        .clr      (clr),
        .ld       (ld),
        .dir      (dir),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {mode, dir, state, ld, clr, timer_clr};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        bit seen = 0;
        for (int i = 0; i < 2 * c_PERIOD; i++) begin
            @(negedge clk);
            if (clks100 === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("tick_timeout", 0, 1);
    endtask

    // Ends one cycle after the accepting tick, with the button(s) still held.
    task automatic press(input logic [4:0] m);
        wait_tick();
        step(1);
        r_btn = r_btn | m;
        wait_tick();
        wait_tick();
        step(1);
    endtask

    task automatic release_btn(input logic [4:0] m);
        r_btn = r_btn & ~m;
        wait_tick();
        wait_tick();
        step(1);
    endtask

    initial begin
        step(3);
        rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) step(1);
            check($sformatf("tick_c%0d", k), clks100, (k % 10 == 9));
            check($sformatf("idle_outs_c%0d", k), outs(), 6'b0);
        end

        // Held btnc: one event, RUN one cycle after the second qualifying tick.
        wait_tick();
        step(1);
        r_btn = c_C;
        wait_tick();
        wait_tick();
        check("run_pre", state, 0);
        step(1);
        check("run_go", state, 1);
        wait_tick();
        step(1);
        check("run_held", state, 1);
        release_btn(c_C);
        check("run_after_rel", state, 1);
        press(c_C);
        check("stop", state, 0);
        release_btn(c_C);

        // Bouncing btnc never reaches two consecutive qualifying samples.
        wait_tick();
        step(1);
        for (int i = 0; i < 15; i++) begin
            r_btn[2] = ((i / 3) % 2 == 0);
            step(1);
        end
        r_btn[2] = 1'b0;
        wait_tick();
        wait_tick();
        wait_tick();
        step(1);
        check("bounce_outs", outs(), 6'b0);

        press(c_D);
        check("dir_set", dir, 1);
        release_btn(c_D);
        press(c_L);
        check("mode_set", mode, 1);
        release_btn(c_L);
        press(c_U);
        check("ld_pulse", ld, 1);
        step(1);
        check("ld_end", ld, 0);
        release_btn(c_U);
        press(c_R);
        check("clr_pulse", {clr, timer_clr}, 2'b10);
        step(1);
        check("clr_end", clr, 0);
        release_btn(c_R);

        // Auto-stop on a down-count at zero.
        press(c_C);
        check("run_down", state, 1);
        release_btn(c_C);
        step(3);
        check("run_mid", state, 1);
        zero = 1'b1;
        step(1);
        check("auto_stop", state, 0);
        zero = 1'b0;
        press(c_L);
        check("done_consume_mode", mode, 1);
        check("done_state", state, 0);
        check("done_dir", dir, 1);
        release_btn(c_L);
        press(c_L);
        check("mode_toggle", mode, 0);
        release_btn(c_L);

        // Simultaneous btnr + btnc in IDLE: clear wins (timer mode now).
        press(c_R | c_C);
        check("prio_clr", {clr, timer_clr}, 2'b01);
        check("prio_state", state, 0);
        step(1);
        check("prio_clr_end", timer_clr, 0);
        check("prio_state2", state, 0);
        release_btn(c_R | c_C);

        // Asynchronous reset while running down in stopwatch mode.
        press(c_L);
        release_btn(c_L);
        press(c_C);
        check("pre_rst", {mode, dir, state}, 3'b111);
        release_btn(c_C);
        step(2);
        rst = 1'b0;
        #1;
        check("rst_outs", outs(), 6'b0);
        check("rst_tick", clks100, 0);
        @(negedge clk);
        rst = 1'b1;
        step(3);
        check("post_rst_outs", outs(), 6'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
